// File: rtl/seg7_pkg.sv
// Shared types, defaults and helpers for the 8-digit 7-segment scan controller.
// lz_mask is only used when SEG7_LZB_EN is defined.
package seg7_pkg;

    typedef enum logic [0:0] {
        StBlank = 1'b0,
        StDrive = 1'b1
    } seg7_state_e;

    localparam logic [7:0]  AN_OFF         = 8'hFF;
    localparam int unsigned NIB_W          = 4;
    localparam int unsigned MAX_DIGITS     = 8;
    localparam int unsigned DEF_NUM_DIGITS = 8;
    localparam int unsigned DEF_TICK_DIV   = 131072;
    localparam int unsigned DEF_BLANK_CYC  = 16;

    // Bit k set when nibbles k..num_digits-1 are all zero; digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [31:0] val,
                                                      input int unsigned num_digits);
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            if (k < int'(num_digits)) begin
                zero_above = zero_above & (val[NIB_W*k +: NIB_W] == 4'h0);
                mask[k]    = zero_above & (k != 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Dwell/blank interval counter for the scan controller: end-of-interval strobe,
// current digit index and a registered pulse that is high during the frame-wrap cycle.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned BLANK_CYC  = DEF_BLANK_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drive_i,
    output logic       end_o,
    output logic [2:0] idx_o,
    output logic       wrap_o
);

    localparam int unsigned MaxCyc = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] TickLast  = CntW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
    localparam logic [2:0]      IdxLast   = 3'(NUM_DIGITS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic            drive_next;

    always_comb begin
        end_o = (cnt_q == (drive_i ? TickLast : BlankLast));
        cnt_d = end_o ? '0 : cnt_q + CntW'(1);
        idx_d = idx_q;
        if (drive_i && end_o) begin
            idx_d = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
        end
        // Look one cycle ahead so the wrap pulse is registered yet aligned with the wrap cycle.
        drive_next = drive_i ^ end_o;
        wrap_d     = drive_next && (cnt_d == TickLast) && (idx_d == IdxLast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for an 8-digit common-anode 7-segment display with a double-buffered value.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned BLANK_CYC  = DEF_BLANK_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] val_in,
    input  logic        val_valid,
    output logic        val_ready,
    input  logic [7:0]  dig_en,
    output logic [3:0]  digit,
    output logic [2:0]  dig_idx,
    output logic [7:0]  AN,
    output logic        frame_done
);

    seg7_state_e state_q;
    logic        drive;
    logic        interval_end;
    logic        wrap;
    logic [31:0] shadow_q;
    logic [31:0] staged_q;
    logic        pending_q;
    logic        xfer;
    logic        show;

    assign drive = (state_q == StDrive);

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .drive_i (drive),
        .end_o   (interval_end),
        .idx_o   (dig_idx),
        .wrap_o  (wrap)
    );

    assign val_ready = ~pending_q;
    assign xfer      = val_valid & ~pending_q;

    // Transfer and shadow load are mutually exclusive: one needs pending clear, the other set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StBlank;
            shadow_q  <= '0;
            staged_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (interval_end) begin
                state_q <= drive ? StBlank : StDrive;
            end
            if (xfer) begin
                staged_q  <= val_in;
                pending_q <= 1'b1;
            end else if (wrap && pending_q) begin
                shadow_q  <= staged_q;
                pending_q <= 1'b0;
            end
        end
    end

`ifdef SEG7_LZB_EN
    logic [MAX_DIGITS-1:0] lz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lz_q <= lz_mask(32'd0, NUM_DIGITS);
        end else if (wrap && pending_q) begin
            lz_q <= lz_mask(staged_q, NUM_DIGITS);
        end
    end

    assign show = ~lz_q[dig_idx];
`else
    assign show = 1'b1;
`endif

    always_comb begin
        AN = AN_OFF;
        if (drive && dig_en[dig_idx] && show) begin
            AN = ~(8'b1 << dig_idx);
        end
    end

    assign digit      = shadow_q[NIB_W*dig_idx +: NIB_W];
    assign frame_done = wrap;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Scan scheduler for the board's 8-digit common-anode 7-segment display.
- Time-multiplexes one hex nibble per digit with a programmable dwell time and an anode-off blanking gap between digits to suppress ghosting.
- Double-buffers the displayed 32-bit value through a valid/ready handshake; a new value takes effect only at a frame boundary.
- Feeds the existing hex-to-cathode decoder (digit nibble in, Cnode out) and drives AN directly.

Parameters:
- NUM_DIGITS, 8, digits scanned (1..8); index wraps at NUM_DIGITS-1.
- TICK_DIV, 131072, clk cycles each digit is driven (DRIVE dwell, >=1).
- BLANK_CYC, 16, clk cycles with all anodes off between digits (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- val_in  in  32  hex value; nibble k = val_in[4k+3:4k] shown on digit k
- val_valid  in  1  val_in offered
- val_ready  out  1  staging buffer free
- dig_en  in  8  per-digit enable; 0 keeps that anode off
- digit  out  4  nibble for the decoder
- dig_idx  out  3  currently scanned digit index
- AN  out  8  anodes, active-low, one-hot-low or all ones
- frame_done  out  1  one-cycle pulse at frame wrap

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values, visible the cycle after rst is sampled high:
  - state=BLANK, dig_idx=0, cnt=0, AN=8'hFF, digit=0
  - shadow=0, staged=0, pending=0, val_ready=1, frame_done=0
- Mid-operation reset discards any pending value and restarts the scan.
- FSM states:
  - BLANK: AN=8'hFF. cnt counts 0..BLANK_CYC-1. At cnt==BLANK_CYC-1, go to DRIVE and set cnt=0.
  - DRIVE: AN=~(8'b1<<dig_idx) when dig_en[dig_idx]=1, else 8'hFF. digit=shadow[4*dig_idx+:4]. cnt counts 0..TICK_DIV-1. At cnt==TICK_DIV-1, go to BLANK, set cnt=0, and advance dig_idx.
- Index advance:
  - If dig_idx==NUM_DIGITS-1, dig_idx wraps to 0 and frame_done pulses high for that one cycle.
  - Otherwise dig_idx increments.
- Frame length is NUM_DIGITS*(TICK_DIV+BLANK_CYC) cycles.
- Handshake:
  - val_ready = ~pending.
  - A transfer occurs when val_valid && val_ready. staged<=val_in and pending<=1 on the next edge.
  - val_in is ignored while val_ready=0.
- Shadow load happens on the frame-wrap cycle: if pending=1, shadow<=staged and pending<=0.
  - val_ready returns high on the following cycle.
  - The new value is displayed from the next DRIVE of digit 0.
- Simultaneous transfer and wrap: transfer requires pending=0, so the wrap cycle loads nothing. The new value is held and applied at the next wrap, so its visible latency is up to two frames.
- dig_en is sampled combinationally each cycle. Changing it mid-DRIVE affects AN immediately.
- dig_en=8'h00: scanning and frame_done continue; AN stays 8'hFF.
- Registered outputs, no combinational path from val_in to AN or digit.
- dig_en bits at positions >= NUM_DIGITS are ignored.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- With the macro:
  - On each shadow load, a registered mask lz[k] is computed. lz[k]=1 iff nibbles k..NUM_DIGITS-1 of the new shadow are all zero and k!=0.
  - In DRIVE, a digit with lz[dig_idx]=1 has AN=8'hFF.
  - Digit 0 is always shown.
  - After reset lz marks digits 1..NUM_DIGITS-1 blanked, since shadow=0.
- Without the macro: no lz logic; all enabled digits display, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - state enum {BLANK, DRIVE}
  - AN_OFF=8'hFF
  - default NUM_DIGITS, TICK_DIV, BLANK_CYC
  - shared nibble width constant (4)
- One sub-module, seg7_scan_timer: parameterized dwell/blank counter. It emits the end-of-interval strobe and the digit index with the wrap pulse.
- The FSM, handshake buffer and AN/digit muxing stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS=8, TICK_DIV=4, BLANK_CYC=2 (48-cycle frame).
1. Reset then idle, dig_en=8'hFF:
   - AN=FF for 2 cycles, then FE for 4 cycles, then FF for 2, then FD, ...
   - digit=0 throughout.
   - frame_done pulses every 48 cycles.
2. Push val_in=32'h1234ABCD mid-frame:
   - val_ready drops for one cycle after the transfer and stays low until the cycle after the wrap.
   - Next frame shows digits 0..7 = D,C,B,A,4,3,2,1.
   - The old frame is unchanged before the wrap.
3. Hold val_valid high with values 32'h11111111 then 32'h22222222:
   - First value is accepted; the second is stalled until the wrap.
   - Frame N+1 shows all 1s, frame N+2 shows all 2s.
4. dig_en=8'b0000_0101:
   - AN goes low only at bit 0 and bit 2 during their DRIVE windows.
   - Other windows show AN=FF with unchanged timing.
5. Assert rst for 1 cycle while dig_idx=5 and pending=1:
   - Next cycle shows the reset values: AN=FF, dig_idx=0, val_ready=1.
   - The pending value never displays.
6. With SEG7_LZB_EN, load 32'h000000A0:
   - Only digits 0 and 1 light, showing 0 and A.
   - Load 32'h0: only digit 0 lights, showing 0.
